// File: rtl/conv_1d_pkg.sv
// Shared definitions for the 1-D BRAM convolution engine.
// Holds the control FSM state type and the helpers that derive the result
// count and the last image index used, so control and datapath agree on them.
package conv_1d_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } conv_ctrl_state_t;

    // Number of stride-aligned windows that fit in the image.
    function automatic int unsigned calc_result_w(input int unsigned img_w,
                                                  input int unsigned filter_l,
                                                  input int unsigned stride_w);
        return (img_w - filter_l) / stride_w + 1;
    endfunction

    // Index of the last image word any window touches.
    function automatic int unsigned calc_last_in(input int unsigned img_w,
                                                 input int unsigned filter_l,
                                                 input int unsigned stride_w);
        return (calc_result_w(img_w, filter_l, stride_w) - 1) * stride_w + filter_l - 1;
    endfunction

endpackage

// File: rtl/conv_1d_valid_delay.sv
// 1-bit delay line of DEPTH cycles with asynchronous active-low clear.
// Ports:
//   clk   - clock
//   reset - asynchronous active-low clear
//   din   - input bit
//   dout  - din delayed by DEPTH cycles
module conv_1d_valid_delay #(
    parameter int unsigned DEPTH = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] sr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr <= '0;
        end else begin
            // Shift left; works for DEPTH == 1 without a special case.
            sr <= (sr << 1) | DEPTH'(din);
        end
    end

    assign dout = sr[DEPTH-1];

endmodule

// File: rtl/conv_bram_1d_ctrl.sv
// Control stage of the 1-D BRAM convolution engine.
// Streams image words from the image BRAM in address order, strobes the
// datapath window shift register when read data is valid, issues one result
// write per completed stride-aligned window, then waits for the datapath's
// last-result flag before pulsing done.
// Ports:
//   clk, reset            - clock, asynchronous active-low reset
//   start                 - run request, sampled in IDLE only
//   busy, done            - status; done is a one-cycle end-of-run pulse
//   img_rden, img_rdaddr  - image BRAM read port
//   dpath_sr_wren         - window shift enable (read data valid)
//   dpath_result_wren/... - result compute/write strobe and its address
//   last_val              - datapath flag: final result written
module conv_bram_1d_ctrl
    import conv_1d_pkg::*;
#(
    parameter int unsigned IMG_W    = 32,
    parameter int unsigned FILTER_L = 3,
    parameter int unsigned STRIDE_W = 1,
    parameter int unsigned RD_LAT   = 1,
    localparam int unsigned RESULT_W = calc_result_w(IMG_W, FILTER_L, STRIDE_W),
    localparam int unsigned LAST_IN  = calc_last_in(IMG_W, FILTER_L, STRIDE_W),
    localparam int unsigned IMG_RAM_ADDR_WIDTH    = $clog2(IMG_W),
    localparam int unsigned RESULT_RAM_ADDR_WIDTH = $clog2(RESULT_W)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    output logic                             busy,
    output logic                             done,
    output logic                             img_rden,
    output logic [IMG_RAM_ADDR_WIDTH-1:0]    img_rdaddr,
    output logic                             dpath_sr_wren,
    output logic                             dpath_result_wren,
    output logic [RESULT_RAM_ADDR_WIDTH-1:0] dpath_result_wraddr,
    input  logic                             last_val
);

    localparam int unsigned IA  = IMG_RAM_ADDR_WIDTH;
    localparam int unsigned RA  = RESULT_RAM_ADDR_WIDTH;
    localparam int unsigned SHW = $clog2(IMG_W + 1);
    localparam int unsigned RCW = $clog2(RESULT_W + 1);
    localparam int unsigned PHW = $clog2(STRIDE_W + 1);

    localparam logic [IA-1:0]  LAST_ADDR = IA'(LAST_IN);
    localparam logic [SHW-1:0] SH_FIRST  = SHW'(FILTER_L - 1);
    localparam logic [PHW-1:0] PH_LAST   = PHW'(STRIDE_W - 1);
    localparam logic [RCW-1:0] RES_FULL  = RCW'(RESULT_W);

    conv_ctrl_state_t state;
    logic [IA-1:0]    rd_cnt;
    logic [SHW-1:0]   sh_cnt;
    logic [PHW-1:0]   ph;
    logic [RCW-1:0]   res_cnt;
    logic             win_done;
    logic             flushed;

    conv_1d_valid_delay #(
        .DEPTH (RD_LAT)
    ) u_rd_valid (
        .clk   (clk),
        .reset (reset),
        .din   (img_rden),
        .dout  (dpath_sr_wren)
    );

    // The word being shifted now (index sh_cnt) closes a window.
    assign win_done = dpath_sr_wren && (sh_cnt >= SH_FIRST) && (ph == '0);

    // All windows strobed and nothing left in flight.
    assign flushed = (res_cnt == RES_FULL) && !dpath_result_wren && !dpath_sr_wren;

    assign busy       = (state != IDLE);
    assign img_rdaddr = rd_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            rd_cnt   <= '0;
            img_rden <= 1'b0;
            done     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state    <= READ;
                        rd_cnt   <= '0;
                        img_rden <= 1'b1;
                    end
                end
                READ: begin
                    if (rd_cnt == LAST_ADDR) begin
                        state    <= DRAIN;
                        rd_cnt   <= '0;
                        img_rden <= 1'b0;
                    end else begin
                        rd_cnt <= rd_cnt + IA'(1);
                    end
                end
                DRAIN: begin
                    if (flushed && last_val) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    img_rden <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

    // Window tracking and result strobe, one cycle behind the completing shift.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh_cnt              <= '0;
            ph                  <= '0;
            res_cnt             <= '0;
            dpath_result_wren   <= 1'b0;
            dpath_result_wraddr <= '0;
        end else begin
            dpath_result_wren <= win_done;
            if (win_done) begin
                dpath_result_wraddr <= res_cnt[RA-1:0];
                res_cnt             <= res_cnt + RCW'(1);
            end
            if (dpath_sr_wren) begin
                sh_cnt <= sh_cnt + SHW'(1);
                // Phase stays at 0 until the first full window, then cycles.
                if (sh_cnt >= SH_FIRST) begin
                    ph <= (ph == PH_LAST) ? '0 : ph + PHW'(1);
                end
            end
            if (state == IDLE && start) begin
                sh_cnt  <= '0;
                ph      <= '0;
                res_cnt <= '0;
            end
        end
    end

endmodule
